// File: rtl/dmix_pkg.sv
// Shared types for the resampler datapath: sample width, sample type and the
// per-channel window-offset field width.
package dmix_pkg;

   localparam int unsigned SAMPLE_W = 24;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // One extra bit over HALFDEPTH_LOG2 spans the full 2*HALFDEPTH window.
   function automatic int unsigned off_w(input int unsigned halfdepth_log2);
      return halfdepth_log2 + 1;
   endfunction

endpackage

// File: rtl/ringbuf_ch.sv
// One channel of the sample ring buffer: storage, pointers, fill count and the
// registered window read. Overflow/underflow flags exist only with RINGBUF_STATUS_EN.
module ringbuf_ch
   import dmix_pkg::*;
#(
   parameter int unsigned HALFDEPTH      = 16,
   parameter int unsigned HALFDEPTH_LOG2 = 4,
   parameter int unsigned DEPTH_LOG2     = 6
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wr_en_i,
   input  sample_t                              wr_data_i,
   input  logic                                 pop_i,
   input  logic [off_w(HALFDEPTH_LOG2)-1:0]     offset_i,
   output sample_t                              data_o,
   output logic                                 ready_o
`ifdef RINGBUF_STATUS_EN
   ,
   input  logic                                 clr_status_i,
   output logic                                 ovf_o,
   output logic                                 udf_o
`endif
);

   localparam int unsigned D = 1 << DEPTH_LOG2;
   localparam int unsigned W = 2 * HALFDEPTH;
   localparam logic [DEPTH_LOG2:0]   DCNT   = (DEPTH_LOG2 + 1)'(D);
   localparam logic [DEPTH_LOG2:0]   WCNT   = (DEPTH_LOG2 + 1)'(W);
   localparam logic [DEPTH_LOG2-1:0] WR_RST = DEPTH_LOG2'(W);

   sample_t               mem_q [D];
   sample_t               data_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q, rd_addr;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ready_q, push_ok, pop_ok;

   // Both decisions use the pre-cycle count, so a same-cycle pop never frees room.
   assign push_ok = wr_en_i && (count_q < DCNT);
   assign pop_ok  = pop_i && (count_q > WCNT);
   assign rd_addr = rd_ptr_q + DEPTH_LOG2'(offset_i);

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Reset prefills the window with W silent samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < D; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= WR_RST;
         count_q  <= WCNT;
         data_q   <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         ready_q <= (count_d > WCNT);
         data_q  <= mem_q[rd_addr];
      end
   end

   assign data_o  = data_q;
   assign ready_o = ready_q;

`ifdef RINGBUF_STATUS_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else if (clr_status_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (wr_en_i && !push_ok) ovf_q <= 1'b1;
         if (pop_i && !pop_ok)    udf_q <= 1'b1;
      end
   end

   assign ovf_o = ovf_q;
   assign udf_o = udf_q;
`endif

endmodule

// File: rtl/ringbuf_array.sv
// Multichannel sample ring buffer feeding the resampler read side. Status flags
// (ovf_o/udf_o/clr_status_i) are present only when RINGBUF_STATUS_EN is defined.
module ringbuf_array
   import dmix_pkg::*;
#(
   parameter int unsigned NUM_CH         = 8,
   parameter int unsigned HALFDEPTH      = 16,
   parameter int unsigned HALFDEPTH_LOG2 = 4,
   parameter int unsigned DEPTH_LOG2     = 6
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      wr_en_i,
   input  logic [$clog2(NUM_CH)-1:0]                 wr_ch_i,
   input  logic [SAMPLE_W-1:0]                       wr_data_i,
   input  logic [NUM_CH-1:0]                         pop_i,
   input  logic [off_w(HALFDEPTH_LOG2)*NUM_CH-1:0]   offset_i,
   output logic [SAMPLE_W*NUM_CH-1:0]                data_o,
   output logic [NUM_CH-1:0]                         ready_o
`ifdef RINGBUF_STATUS_EN
   ,
   input  logic                                      clr_status_i,
   output logic [NUM_CH-1:0]                         ovf_o,
   output logic [NUM_CH-1:0]                         udf_o
`endif
);

   localparam int unsigned CH_W = $clog2(NUM_CH);
   localparam int unsigned OW   = off_w(HALFDEPTH_LOG2);

   logic [NUM_CH-1:0] push_sel;

   always_comb begin
      push_sel = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         push_sel[c] = wr_en_i && (wr_ch_i == CH_W'(c));
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      ringbuf_ch #(
         .HALFDEPTH      (HALFDEPTH),
         .HALFDEPTH_LOG2 (HALFDEPTH_LOG2),
         .DEPTH_LOG2     (DEPTH_LOG2)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .wr_en_i      (push_sel[c]),
         .wr_data_i    (wr_data_i),
         .pop_i        (pop_i[c]),
         .offset_i     (offset_i[c*OW +: OW]),
         .data_o       (data_o[c*SAMPLE_W +: SAMPLE_W]),
         .ready_o      (ready_o[c])
`ifdef RINGBUF_STATUS_EN
         ,
         .clr_status_i (clr_status_i),
         .ovf_o        (ovf_o[c]),
         .udf_o        (udf_o[c])
`endif
      );
   end

endmodule
